// File: rtl/tri_mon.sv
// Triangle-wave monitor: tracks slope, peaks, valleys, valley-to-valley period and illegal steps.
// Latency: one cycle; every output is registered on the edge that accepts the sample.
// Backpressure: none; din is consumed only when din_vld=1, and all state holds otherwise.
module tri_mon #(
  parameter int STEP  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             din_vld,
  input  logic [8:0]       din,
  output logic             dir,
  output logic [8:0]       peak_val,
  output logic [8:0]       valley_val,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, SEED, RISE, FALL} state_t;

  localparam logic signed [9:0] STEP_POS = 10'(STEP);
  localparam logic signed [9:0] STEP_NEG = -STEP_POS;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic [8:0]        prev;
  logic [CNT_W-1:0]  smp_cnt;
  logic [CNT_W-1:0]  valley_idx;
  logic [CNT_W-1:0]  period_new;
  logic              armed;
  logic signed [9:0] delta;
  logic              step_up;
  logic              step_dn;
  logic              bad_step;
  logic              peak_hit;
  logic              valley_hit;
  logic              dir_d;

  // Plain signed difference: 511->0 and 0->511 come out as +/-511, never as a legal step.
  assign delta   = $signed({1'b0, din}) - $signed({1'b0, prev});
  assign step_up = (delta == STEP_POS);
  assign step_dn = (delta == STEP_NEG);

  // Valleys are stamped with the index of the detecting sample; the difference equals
  // the distance between the valley samples themselves.
  assign period_new = smp_cnt - valley_idx;

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-sample event strobes.
  always_comb begin
    state_d    = state_q;
    bad_step   = 1'b0;
    peak_hit   = 1'b0;
    valley_hit = 1'b0;
    dir_d      = dir;
    if (din_vld) begin
      case (state_q)
        IDLE: begin
          state_d = SEED;
        end
        SEED: begin
          if (step_up) begin
            state_d = RISE;
            dir_d   = 1'b1;
          end else if (step_dn) begin
            state_d = FALL;
            dir_d   = 1'b0;
          end else begin
            bad_step = 1'b1;
            dir_d    = 1'b0;
          end
        end
        RISE: begin
          if (step_dn) begin
            peak_hit = 1'b1;
            state_d  = FALL;
            dir_d    = 1'b0;
          end else if (!step_up) begin
            bad_step = 1'b1;
            state_d  = SEED;
            dir_d    = 1'b0;
          end
        end
        FALL: begin
          if (step_up) begin
            valley_hit = 1'b1;
            state_d    = RISE;
            dir_d      = 1'b1;
          end else if (!step_dn) begin
            bad_step = 1'b1;
            state_d  = SEED;
            dir_d    = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath: sample history, extremes, period measurement and error accounting.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      prev       <= '0;
      smp_cnt    <= '0;
      valley_idx <= '0;
      armed      <= 1'b0;
      dir        <= 1'b0;
      peak_val   <= '0;
      valley_val <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      step_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      period_vld <= 1'b0;
      step_err   <= 1'b0;
      if (din_vld) begin
        prev <= din;
        dir  <= dir_d;
        if (smp_cnt != '1) begin
          smp_cnt <= smp_cnt + CNT_ONE;
        end
        if (peak_hit) begin
          peak_val <= prev;
        end
        if (valley_hit) begin
          valley_val <= prev;
          valley_idx <= smp_cnt;
          armed      <= 1'b1;
          // The first valley after a (re)start only arms; later ones report a period.
          if (armed) begin
            period     <= period_new;
            period_vld <= 1'b1;
            locked     <= (period_new == period);
          end
        end
        if (bad_step) begin
          step_err <= 1'b1;
          locked   <= 1'b0;
          armed    <= 1'b0;
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/tri_mon.md
TRI_MON -- requirements
Module: tri_mon

Interface
REQ-001 Parameter: STEP, default 1, required absolute difference between consecutive valid samples.
REQ-002 Parameter: CNT_W, default 16, width of the period counter and the period output.
REQ-003 Port: clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port: res  in  1  reset, asynchronous, active-high.
REQ-005 Port: din_vld  in  1  sample qualifier; din is consumed only on an edge where din_vld=1.
REQ-006 Port: din  in  9  unsigned input sample (triangle stream, 0..511).
REQ-007 Port: dir  out  1  current slope; 1=rising, 0=falling/unknown.
REQ-008 Port: peak_val  out  9  most recent detected peak value.
REQ-009 Port: valley_val  out  9  most recent detected valley value.
REQ-010 Port: period  out  CNT_W  valid-sample count between the last two valleys.
REQ-011 Port: period_vld  out  1  one-cycle pulse when period updates.
REQ-012 Port: locked  out  1  high while the last two measured periods are equal.
REQ-013 Port: step_err  out  1  one-cycle pulse on an illegal step.
REQ-014 Port: err_cnt  out  8  count of illegal steps, saturating at 255.

Function
REQ-015 States: IDLE (no history), SEED (one sample held, slope unknown), RISE, FALL; prev[8:0] holds the last accepted sample.
REQ-016 All state, counters and outputs SHALL hold when din_vld=0.
REQ-017 delta = din - prev, computed 10-bit signed; legal iff delta = +STEP or -STEP.
REQ-018 IDLE: valid sample -> prev<=din, go to SEED; no error possible.
REQ-019 SEED: +STEP -> RISE, dir<=1; -STEP -> FALL, dir<=0; illegal -> step_err, stay in SEED.
REQ-020 RISE: +STEP -> stay; -STEP -> peak_val<=prev, go to FALL, dir<=0; illegal -> step_err, go to SEED.
REQ-021 FALL: -STEP -> stay; +STEP -> valley_val<=prev, go to RISE, dir<=1; illegal -> step_err, go to SEED.
REQ-022 prev<=din on every valid sample in every state, including illegal steps.
REQ-023 Zero delta (repeated sample) is illegal.
REQ-024 Sample counter increments on each valid sample and saturates at all-ones.
REQ-025 Period measurement: period = index difference of successive valley samples (valley sample to valley sample).
- The first valley after IDLE/SEED only arms the measurement; no period_vld.
REQ-026 period_vld SHALL pulse on the edge accepting the sample that detects the second and later valleys; period updates on the same edge.
REQ-027 All outputs registered; peak/valley/period update on the same edge that accepts the detecting sample (one-cycle latency from din).
REQ-028 locked<=1 when a new period equals the previous period; locked<=0 when it differs or on any step_err.
REQ-029 Any step_err disarms the period measurement; the next valley only re-arms it.
REQ-030 err_cnt increments on each step_err and saturates at 255.
REQ-031 Wrap-around: din 511->0 or 0->511 SHALL be treated as an illegal step (no modular arithmetic).

Reset
REQ-032 Asserting res SHALL asynchronously force IDLE; prev, sample counter and measurement arm all cleared.
REQ-033 Reset values: dir=0, peak_val=0, valley_val=0, period=0, period_vld=0, locked=0, step_err=0, err_cnt=0.
REQ-034 Reset asserted mid-waveform SHALL discard all history; after release the block restarts at IDLE on the next valid sample.

Verification
REQ-035 Continuous 0,1,..,300,299,..,1,0,1.. with din_vld=1 -> peak_val=300, valley_val=0, period=600, period_vld pulses once per cycle after the first valley, locked=1 from the second period.
REQ-036 Same stream with din_vld toggling 1/0 -> identical peak_val, valley_val, period (600) and locked; outputs stable while din_vld=0.
REQ-037 Inject 150 -> 152 on the rising slope -> step_err pulses once, err_cnt=1, locked=0, state SEED, next period_vld only after two more valleys.
REQ-038 Repeat a sample (e.g. 40,40) -> step_err pulse, err_cnt increments; 300 consecutive errors -> err_cnt holds at 255.
REQ-039 Assert res at sample 200 of the rise -> all outputs 0 asynchronously; after release the full stream re-measures period=600.
REQ-040 STEP=2 with stream 0,2,..,100,98,..,0 -> peak_val=100, valley_val=0, period=100, no step_err.
